// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: definitions shared by the SPI command transmitter and the
// oscillator command decoder on the receiving side.
//   - spi_state_e  : transmitter FSM states
//   - CMD_WIDTH_DEF / DATA_WIDTH_DEF : default packet field widths
//   - OP_*         : command opcodes understood by the command decoder
package spi_cmd_pkg;

  localparam int CMD_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  localparam logic [CMD_WIDTH_DEF-1:0] OP_NOP         = 8'h00;
  localparam logic [CMD_WIDTH_DEF-1:0] OP_OSC0_TUNE   = 8'h01;
  localparam logic [CMD_WIDTH_DEF-1:0] OP_OSC1_TUNE   = 8'h02;
  localparam logic [CMD_WIDTH_DEF-1:0] OP_OSC0_PHASE  = 8'h03;
  localparam logic [CMD_WIDTH_DEF-1:0] OP_OSC1_PHASE  = 8'h04;
  localparam logic [CMD_WIDTH_DEF-1:0] OP_OUT_ENABLE  = 8'h10;

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: free-running divider that pulses tick once every CLK_DIV
// clk cycles. restart forces the count back to zero so that the next tick
// arrives exactly CLK_DIV cycles after the restart edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : synchronous restart of the count
//   tick       : high during the last cycle of each CLK_DIV period
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + CW'(1);
    if (restart || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_cmd_tx.sv
// spi_cmd_tx: serializes {cmd_word, data_word} as one MSB-first SPI mode-0
// packet on sclk/mosi/csb, with a one-entry pending buffer so the next
// packet can be queued while the current one is on the wire.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_word, data_word : packet fields (command goes out first)
//   valid / ready       : accept handshake; ready = pending buffer empty
//   sclk, mosi, csb     : SPI bus, all driven straight from flops
//   busy                : transfer in progress or packet pending
//   done                : one-cycle pulse as csb returns high
module spi_cmd_tx
  import spi_cmd_pkg::*;
#(
  parameter int CMD_WIDTH    = CMD_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PACKET_WIDTH = CMD_WIDTH + DATA_WIDTH,
  parameter int CLK_DIV      = 4,
  parameter int CS_GAP       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_WIDTH-1:0]  cmd_word,
  input  logic [DATA_WIDTH-1:0] data_word,
  input  logic                  valid,
  output logic                  ready,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = $clog2(PACKET_WIDTH);
  localparam int GW  = $clog2(CS_GAP + 1);
  localparam logic [BCW-1:0] BIT_TOP  = BCW'(PACKET_WIDTH - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(CS_GAP - 1);

  spi_state_e              state_q, state_d;
  logic                    pend_full_q, pend_full_d;
  logic [PACKET_WIDTH-1:0] pend_q, pend_d;
  logic [PACKET_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    csb_q, csb_d;
  logic                    done_q, done_d;
  logic                    restart, tick, load;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // ready and busy decode only flops, so valid never reaches ready.
  assign ready = !pend_full_q;
  assign busy  = (state_q != IDLE) || pend_full_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign csb   = csb_q;
  assign done  = done_q;

  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    csb_d       = csb_q;
    done_d      = 1'b0;
    restart     = 1'b0;
    load        = 1'b0;

    // Accept and load are mutually exclusive: accept needs an empty buffer,
    // load needs a full one.
    if (valid && !pend_full_q) begin
      pend_d      = {cmd_word, data_word};
      pend_full_d = 1'b1;
    end

    // Output flops take the value of the state being entered, so every bus
    // pin changes on the same edge as the state register.
    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          load = 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          restart = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          restart = 1'b1;
          sclk_d  = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d   = LOW;
            shreg_d   = {shreg_q[PACKET_WIDTH-2:0], 1'b0};
            mosi_d    = shreg_q[PACKET_WIDTH-2];
            bit_cnt_d = bit_cnt_q - BCW'(1);
          end
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          restart = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = GAP;
          csb_d     = 1'b1;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          restart   = 1'b1;
        end
      end
      GAP: begin
        // The divider wraps on its own tick, so intermediate gap
        // half-periods need no restart.
        if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            if (pend_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    // Move the pending packet onto the wire; the buffer frees this cycle.
    if (load) begin
      state_d     = SETUP;
      shreg_d     = pend_q;
      pend_full_d = 1'b0;
      bit_cnt_d   = BIT_TOP;
      csb_d       = 1'b0;
      sclk_d      = 1'b0;
      mosi_d      = pend_q[PACKET_WIDTH-1];
      restart     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      csb_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      csb_q       <= csb_d;
      done_q      <= done_d;
    end
  end

  // Packet payload flops carry no reset: their contents only matter once
  // pend_full_q or the FSM state says they are valid.
  always_ff @(posedge clk) begin
    pend_q  <= pend_d;
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_spi_cmd_tx.sv
module tb_spi_cmd_tx;

  localparam int D    = 4;
  localparam int G    = 2;
  localparam int PW   = 24;
  localparam int LOWT = 49 * D;
  localparam int FRM  = (49 + G) * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_word = '0;
  logic [15:0] data_word = '0;
  logic        valid = 1'b0;
  logic        ready, sclk, mosi, csb, busy, done;

  spi_cmd_tx #(
    .CMD_WIDTH  (8),
    .DATA_WIDTH (16),
    .CLK_DIV    (D),
    .CS_GAP     (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_word  (cmd_word),
    .data_word (data_word),
    .valid     (valid),
    .ready     (ready),
    .sclk      (sclk),
    .mosi      (mosi),
    .csb       (csb),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: packet timeline ----------------
  // A packet is a frame of FRM cycles starting the cycle csb falls; the
  // outputs are a pure function of the offset t inside the frame.
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [23:0] m_frame = '0;
  bit          m_pend = 1'b0;
  logic [23:0] m_pend_data = '0;
  logic [23:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    bit pend_b, acc;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_t      = 0;
    end else begin
      pend_b = m_pend;
      acc    = valid && !m_pend;
      if (m_active && m_t < FRM - 1) begin
        m_t++;
      end else begin
        m_active = 1'b0;
        if (pend_b) begin
          m_active = 1'b1;
          m_t      = 0;
          m_frame  = m_pend_data;
          m_pend   = 1'b0;
        end
      end
      if (acc) begin
        m_pend      = 1'b1;
        m_pend_data = {cmd_word, data_word};
      end
      if (m_active && m_t == LOWT) exp_q.push_back(m_frame);
    end
  end

  // {csb, sclk, mosi, done, ready, busy}
  function automatic logic [5:0] model_out();
    int h, idx;
    logic c, s, m, dn;
    c = 1'b1; s = 1'b0; m = 1'b0; dn = 1'b0;
    if (m_active) begin
      h = m_t / D;
      if (h == 0) begin
        c = 1'b0; m = m_frame[23];
      end else if (h <= 47) begin
        c = 1'b0;
        if (h % 2 == 1) begin s = 1'b1; idx = 23 - (h - 1) / 2; end
        else            begin s = 1'b0; idx = 23 - h / 2;       end
        m = m_frame[idx];
      end else if (h == 48) begin
        c = 1'b0;
      end else begin
        dn = (m_t == LOWT);
      end
    end
    return {c, s, m, dn, !m_pend, m_active || m_pend};
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) check("outputs{csb,sclk,mosi,done,ready,busy}",
                      {58'd0, csb, sclk, mosi, done, ready, busy}, {58'd0, model_out()});
  end

  // ---------------- bus monitor (acts as the SPI receiver) ----------------
  logic        prev_csb = 1'b1, prev_sclk = 1'b0;
  logic [23:0] rx_bits = '0;
  int          rx_n = 0;
  logic [23:0] rx_q[$];
  int csb_low_cnt = 0, nrise = 0, ndone = 0, nfall = 0;
  int fall_cyc = 0, rise_cyc = 0, first_sclk_cyc = 0, last_gap = 0, last_period = 0;

  initial forever begin
    @(negedge clk);
    if (csb == 1'b0) csb_low_cnt++;
    if (prev_csb && !csb) begin
      last_gap    = cyc - rise_cyc;
      last_period = cyc - fall_cyc;
      fall_cyc    = cyc;
      nfall++;
      rx_n = 0;
    end
    if (!csb && !prev_sclk && sclk) begin
      rx_bits = {rx_bits[22:0], mosi};
      rx_n++;
      nrise++;
      if (rx_n == 1) first_sclk_cyc = cyc;
    end
    if (!prev_csb && csb) begin
      rise_cyc = cyc;
      if (rx_n == PW) rx_q.push_back(rx_bits);
    end
    if (done) ndone++;
    prev_csb  = csb;
    prev_sclk = sclk;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] c, input logic [15:0] d, output int acc_cyc);
    int n;
    cmd_word = c; data_word = d; valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_seen", ready, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    #2;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
    #2;
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, base, n, nf;

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    check("reset_csb", csb, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_ready", ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    resync();

    // Single packet 0x03 / 0xA5C3
    csb_low_cnt = 0; nrise = 0; ndone = 0;
    base = rx_q.size();
    send(8'h03, 16'hA5C3, acc);
    wait_done(400);
    check("single_csb_low_cycles", csb_low_cnt, 196);
    check("single_sclk_rises", nrise, 24);
    check("single_rx_count", rx_q.size() - base, 1);
    if (rx_q.size() > base) check("single_rx_word", rx_q[base], 24'h03A5C3);
    check("latency_csb_fall", fall_cyc - acc, 1);
    check("latency_first_sclk", first_sclk_cyc - acc, 1 + D);
    repeat (20) @(negedge clk);
    #2;
    check("single_done_pulses", ndone, 1);
    resync();

    // Back-to-back: 0x02/0xFFFF then 0x01/0x1234 queued behind it
    base = rx_q.size();
    send(8'h02, 16'hFFFF, acc);
    send(8'h01, 16'h1234, acc);
    @(negedge clk);
    check("b2b_ready_low_while_pending", ready, 1'b0);
    wait_done(400);
    nf = nfall;
    n = 0;
    while (nfall == nf && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("b2b_second_started", nfall - nf, 1);
    check("b2b_gap_cycles", last_gap, G * D);
    check("b2b_period_cycles", last_period, FRM);
    wait_done(400);
    check("b2b_rx_count", rx_q.size() - base, 2);
    if (rx_q.size() > base + 1) begin
      check("b2b_rx_first", rx_q[base], 24'h02FFFF);
      check("b2b_rx_second", rx_q[base + 1], 24'h011234);
    end
    resync();

    // Backpressure: valid held with changing data while ready is low
    base = rx_q.size();
    send(8'h10, 16'h0001, acc);
    send(8'h20, 16'h0002, acc);
    valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready && n < 1000) begin
      cmd_word  = 8'($urandom);
      data_word = 16'($urandom);
      @(negedge clk);
      n++;
    end
    cmd_word = 8'h5A; data_word = 16'h9876;
    @(posedge clk); #1;
    valid = 1'b0;
    wait_idle(1500);
    check("bp_rx_count", rx_q.size() - base, 3);
    if (rx_q.size() > base + 2) begin
      check("bp_rx_a", rx_q[base], 24'h100001);
      check("bp_rx_b", rx_q[base + 1], 24'h200002);
      check("bp_rx_c", rx_q[base + 2], 24'h5A9876);
    end
    resync();

    // Reset mid-packet with a second packet pending
    base = rx_q.size();
    send(8'h33, 16'hCAFE, acc);
    send(8'h44, 16'hBEEF, acc);
    repeat (80) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_csb", csb, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_ready", ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    nf = nfall;
    repeat (300) @(posedge clk);
    #1;
    check("midrst_no_rx", rx_q.size() - base, 0);
    check("midrst_no_restart", nfall - nf, 0);

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      valid     = ($urandom_range(0, 7) == 0);
      cmd_word  = 8'($urandom);
      data_word = 16'($urandom);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_idle(1000);

    check("sb_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check("sb_word", rx_q[i], exp_q[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_cmd_tx.md
# spi_cmd_tx

SPI command transmitter: the host-side counterpart of the DDS control-port SPI receiver. It takes an 8-bit command and a 16-bit data word over a valid/ready handshake and serializes them as one 24-bit packet on `sclk`/`mosi`/`csb`. It has a one-entry pending buffer, so a second packet can be queued while the first is on the wire. It is used in the bench and in loopback/self-test builds to drive the oscillator command decoder.

## Interface
- `CMD_WIDTH`, 8: command field width.
- `DATA_WIDTH`, 16: data field width.
- `PACKET_WIDTH`, `CMD_WIDTH+DATA_WIDTH` (24): bits per packet.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period. Must be ≥ 2; ≥ 4 is required when driving the synchronizing receiver.
- `CS_GAP`, 2: minimum `csb`-high time between packets, in half-periods. Must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_word` in `CMD_WIDTH`: command byte, sent first.
- `data_word` in `DATA_WIDTH`: data word, sent after the command.
- `valid` in 1: packet offered.
- `ready` out 1: pending buffer empty; transfer occurs when `valid && ready` at a rising `clk` edge.
- `sclk` out 1: SPI clock, idles low (mode 0).
- `mosi` out 1: serial data, MSB-first.
- `csb` out 1: chip select, active low.
- `busy` out 1: FSM not in IDLE, or pending buffer full.
- `done` out 1: one-cycle pulse when `csb` returns high at the end of a packet.

## Operation
- Accept: `{cmd_word,data_word}` is written into the pending buffer and `pend_full` is set. `ready = !pend_full`, decoded from registers only, with no combinational path from `valid`.
- FSM states:
  - IDLE: if `pend_full`, load the shift register, clear `pend_full`, go to SETUP.
  - SETUP: `csb`=0, `sclk`=0, `mosi`=bit 23. Lasts 1 half-period, then go to HIGH.
  - HIGH: `sclk`=1; the receiver samples `mosi` on this rising edge. Lasts 1 half-period. At its end, go to LOW if bits remain, else HOLD.
  - LOW: `sclk`=0, shift; `mosi` = next bit. Lasts 1 half-period, then go to HIGH.
  - HOLD: `sclk`=0, `csb`=0, `mosi`=0. Lasts 1 half-period, then go to GAP.
  - GAP: `csb`=1. `done` pulses on the first cycle. Lasts `CS_GAP` half-periods. At its end, go to SETUP if `pend_full` (load as in IDLE), else IDLE.
- A bit counter runs 23→0. Wire order is `cmd[7]…cmd[0]`, then `data[15]…data[0]`.
- `mosi` is 0 whenever `csb`=1.
- All outputs are registered (no glitches on `sclk`/`csb`).

## Timing
- Reset values: `sclk`=0, `mosi`=0, `csb`=1, `ready`=1, `busy`=0, `done`=0. Pending buffer is empty.
- Latency: accept at edge N with the FSM in IDLE:
  - `csb` falls and `mosi`=bit 23 after edge N+1.
  - First `sclk` rise after edge N+1+`CLK_DIV`.
- `csb` low time is exactly 49·`CLK_DIV` cycles: 1 setup, 24 high, 23 low, and 1 hold half-periods.
- Back-to-back packets: packet period is (49+`CS_GAP`)·`CLK_DIV` cycles. A packet queued during a transfer starts with no IDLE cycle.
- The pending buffer is loaded in the same cycle it is freed, and `ready` rises on the next cycle. Accept and load cannot coincide, because `ready`=0 while the buffer is full.
- `valid` held while `ready`=0: no effect. Inputs are ignored and nothing is sampled.
- `rst_n` asserted mid-packet: outputs return to their reset values immediately (asynchronous). The packet in flight and the pending packet are both dropped. The early `csb` rise aborts the packet, and the receiver never flags it valid.
- Max SCLK = `clk`/(2·`CLK_DIV`).

## Structure
- Shared package `spi_cmd_pkg` holds:
  - the FSM state enum (`IDLE`, `SETUP`, `HIGH`, `LOW`, `HOLD`, `GAP`);
  - the `CMD_WIDTH`/`DATA_WIDTH` defaults;
  - the command opcode constants shared with the command decoder.
- Sub-module `spi_tick_gen`: a free-running counter with synchronous restart that pulses `tick` every `CLK_DIV` cycles. The FSM restarts it on each state entry.

## Test plan
- **Reset:** assert `rst_n` mid-packet → `csb`=1, `sclk`=0, `mosi`=0, `ready`=1 in the same cycle. The receiver reports no `cmd_valid`.
- **Single packet:** send cmd 0x03, data 0xA5C3 with `CLK_DIV`=4 → `csb` low for exactly 196 cycles and 24 `sclk` rises. Bits sampled on the rises read 0x03A5C3. `done` pulses once.
- **Back-to-back:** queue 0x01/0x1234 during packet 0x02/0xFFFF → `ready`=0 until packet 2 loads. Gap between packets is 8 cycles. The receiver decodes both, in order.
- **Backpressure:** hold `valid` with changing data while `ready`=0 → only the values present at the accept edge are transmitted.
- **Loopback:** connect to the SPI receiver and command decoder, write a tune word 0x0400 to oscillator 0 → decoder `osc0_tune`=0x0400 within one cycle of `cmd_valid`.
